// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main control FSM.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// control lines, including the 3-bit alu_op code consumed by ALU_Control.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   opcode_i, funct_i   - IR[31:26] and IR[5:0], sampled in DECODE
//   zero_i              - ALU zero flag (branch resolution)
//   mem_ready_i         - memory completes the current access this cycle
//   pc_write_o .. pc_source_o - datapath enables and mux selects
//   state_o             - current state (debug)
//   illegal_o           - one-cycle pulse on an unsupported instruction
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned STATE_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [OPCODE_W-1:0] funct_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                i_or_d_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                reg_write_o,
    output logic [1:0]          reg_dst_o,
    output logic [1:0]          mem_to_reg_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [2:0]          alu_op_o,
    output logic [1:0]          pc_source_o,
    output logic [STATE_W-1:0]  state_o,
    output logic                illegal_o
);

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LUI  = OPCODE_W'(6'b001111);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'b001100);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'b000011);

    localparam logic [OPCODE_W-1:0] FN_JR   = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] FN_ADD  = OPCODE_W'(6'b100000);
    localparam logic [OPCODE_W-1:0] FN_SUB  = OPCODE_W'(6'b100010);
    localparam logic [OPCODE_W-1:0] FN_AND  = OPCODE_W'(6'b100100);
    localparam logic [OPCODE_W-1:0] FN_OR   = OPCODE_W'(6'b100101);
    localparam logic [OPCODE_W-1:0] FN_NOR  = OPCODE_W'(6'b100111);
    localparam logic [OPCODE_W-1:0] FN_SLL  = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] FN_SRL  = OPCODE_W'(6'b000010);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_JR        = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [OPCODE_W-1:0] r_op;
    logic [OPCODE_W-1:0] r_fn;
    logic                w_fn_legal;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Instruction fields latched in DECODE for use by later states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= '0;
            r_fn <= '0;
        end else if (r_state == S_DECODE) begin
            r_op <= opcode_i;
            r_fn <= funct_i;
        end
    end

    assign w_fn_legal = funct_i inside {FN_ADD, FN_SUB, FN_AND, FN_OR,
                                        FN_NOR, FN_SLL, FN_SRL};
    assign state_o    = r_state;

    // Next-state and control decode
    always_comb begin
        w_next       = r_state;
        pc_write_o   = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'd0;
        mem_to_reg_o = 2'd0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'd0;
        alu_op_o     = 3'b000;
        pc_source_o  = 2'd0;
        illegal_o    = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'd1;
                alu_op_o    = 3'b100;
                // Reset forces FETCH; the input-driven writes must stay off while held
                if (mem_ready_i) begin
                    ir_write_o = ~reset;
                    pc_write_o = ~reset;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b_o = 2'd3;
                alu_op_o    = 3'b100;
                case (opcode_i)
                    OP_R: begin
                        if (funct_i == FN_JR) begin
                            w_next = S_JR;
                        end else if (w_fn_legal) begin
                            w_next = S_EXEC_R;
                        end else begin
                            w_next = S_ILLEGAL;
                        end
                    end
                    OP_LW, OP_SW:                      w_next = S_MEM_ADDR;
                    OP_ADDI, OP_LUI, OP_ORI, OP_ANDI:  w_next = S_EXEC_I;
                    OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
                    OP_J, OP_JAL:                      w_next = S_JUMP;
                    default:                           w_next = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = 3'b101;
                w_next      = (r_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                if (mem_ready_i) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'd1;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                if (mem_ready_i) begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b111;
                w_next      = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                case (r_op)
                    OP_LUI:  alu_op_o = 3'b001;
                    OP_ORI:  alu_op_o = 3'b010;
                    OP_ANDI: alu_op_o = 3'b011;
                    default: alu_op_o = 3'b100;
                endcase
                w_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (r_op == OP_R) ? 2'd1 : 2'd0;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b110;
                pc_source_o = 2'd1;
                pc_write_o  = ((r_op == OP_BEQ) &  zero_i) |
                              ((r_op == OP_BNE) & ~zero_i);
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'd2;
                // jal links PC (already PC+4) into $31
                if (r_op == OP_JAL) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 2'd2;
                    mem_to_reg_o = 2'd2;
                end
                w_next = S_FETCH;
            end
            S_JR: begin
                // Redirect only on the latched jr funct that selected this state
                pc_write_o  = (r_fn == FN_JR);
                pc_source_o = 2'd3;
                alu_op_o    = 3'b111;
                w_next      = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_o = 1'b1;
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// Each instruction is expanded into its expected per-cycle control vectors,
// queued, and compared against the DUT on every falling clock edge.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic       sa;
        logic [1:0] sb;
        logic [2:0] aop;
        logic [1:0] ps;
        logic       ill;
    } vec_t;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4,
                   K_J = 5, K_JR = 6, K_ILL = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
    logic       reg_write_o, alu_src_a_o, illegal_o;
    logic [1:0] reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_source_o;
    logic [2:0] alu_op_o;
    logic [3:0] state_o;

    vec_t q[$];
    int   obs_st[$];
    int   ir_cnt;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_cnt;
    int   add_tr[4]  = '{0, 1, 6, 7};
    int   lw_tr[10]  = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};

    multicycle_control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .opcode_i     (opcode_i),
        .funct_i      (funct_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write_o),
        .i_or_d_o     (i_or_d_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .ir_write_o   (ir_write_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .pc_source_o  (pc_source_o),
        .state_o      (state_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk = ~clk;

    // Instruction class from the opcode/funct table
    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                if (fn == 6'b001000) return K_JR;
                case (fn)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b100111, 6'b000000, 6'b000010: return K_R;
                    default: return K_ILL;
                endcase
            end
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b001000, 6'b001111, 6'b001101, 6'b001100: return K_I;
            6'b000100, 6'b000101: return K_BR;
            6'b000010, 6'b000011: return K_J;
            default: return K_ILL;
        endcase
    endfunction

    function automatic vec_t v0(input int st);
        vec_t v;
        v    = '0;
        v.st = 4'(st);
        return v;
    endfunction

    function automatic vec_t fetch_vec(input logic done);
        vec_t v;
        v     = v0(0);
        v.mr  = 1'b1;
        v.sb  = 2'd1;
        v.aop = 3'b100;
        v.pcw = done;
        v.irw = done;
        return v;
    endfunction

    task automatic step(input vec_t v);
        q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expand one instruction into expected cycles and drive it
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fw, input int mwt,
                             output int cyc);
        vec_t v;
        int   k;
        k   = kind(op, fn);
        cyc = 0;
        obs_st.delete();
        ir_cnt   = 0;
        opcode_i = op;
        funct_i  = fn;
        zero_i   = z;
        for (int i = 0; i <= fw; i++) begin
            mem_ready_i = (i == fw);
            step(fetch_vec(i == fw));
            cyc++;
        end
        mem_ready_i = 1'b1;
        v = v0(1); v.sb = 2'd3; v.aop = 3'b100;
        step(v); cyc++;
        case (k)
            K_R, K_I: begin
                v = v0(k == K_R ? 6 : 8);
                v.sa = 1'b1;
                v.sb = (k == K_R) ? 2'd0 : 2'd2;
                if (k == K_R)            v.aop = 3'b111;
                else if (op == 6'b001111) v.aop = 3'b001;
                else if (op == 6'b001101) v.aop = 3'b010;
                else if (op == 6'b001100) v.aop = 3'b011;
                else                      v.aop = 3'b100;
                step(v); cyc++;
                v = v0(7); v.rw = 1'b1; v.rd = (k == K_R) ? 2'd1 : 2'd0;
                step(v); cyc++;
            end
            K_LW, K_SW: begin
                v = v0(2); v.sa = 1'b1; v.sb = 2'd2; v.aop = 3'b101;
                step(v); cyc++;
                for (int i = 0; i <= mwt; i++) begin
                    mem_ready_i = (i == mwt);
                    v = v0(k == K_LW ? 3 : 5);
                    v.iord = 1'b1;
                    v.mr   = (k == K_LW);
                    v.mw   = (k == K_SW);
                    step(v); cyc++;
                end
                mem_ready_i = 1'b1;
                if (k == K_LW) begin
                    v = v0(4); v.rw = 1'b1; v.m2r = 2'd1;
                    step(v); cyc++;
                end
            end
            K_BR: begin
                v = v0(9); v.sa = 1'b1; v.aop = 3'b110; v.ps = 2'd1;
                v.pcw = (op == 6'b000100) ? z : ~z;
                step(v); cyc++;
            end
            K_J: begin
                v = v0(10); v.pcw = 1'b1; v.ps = 2'd2;
                if (op == 6'b000011) begin
                    v.rw = 1'b1; v.rd = 2'd2; v.m2r = 2'd2;
                end
                step(v); cyc++;
            end
            K_JR: begin
                v = v0(11); v.pcw = 1'b1; v.ps = 2'd3; v.aop = 3'b111;
                step(v); cyc++;
            end
            default: begin
                v = v0(12); v.ill = 1'b1;
                step(v); cyc++;
            end
        endcase
        chk("back_to_fetch", int'(state_o), 0);
    endtask

    // Per-cycle comparison against the queued expectation
    always @(negedge clk) begin
        vec_t e;
        vec_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{st: state_o, pcw: pc_write_o, iord: i_or_d_o, mr: mem_read_o,
                  mw: mem_write_o, irw: ir_write_o, rw: reg_write_o,
                  rd: reg_dst_o, m2r: mem_to_reg_o, sa: alu_src_a_o,
                  sb: alu_src_b_o, aop: alu_op_o, ps: pc_source_o,
                  ill: illegal_o};
            obs_st.push_back(int'(state_o));
            if (ir_write_o) ir_cnt++;
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs@t=%0t exp_state=%0d: got %h expected %h",
                         $time, e.st, a, e);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t mwv;
        reset       = 1'b1;
        mem_ready_i = 1'b1;
        opcode_i    = 6'b000000;
        funct_i     = 6'b100000;
        zero_i      = 1'b0;
        @(posedge clk);
        #1;
        // Held reset: FETCH outputs, no writes even with memory ready
        repeat (3) step(fetch_vec(1'b0));
        reset = 1'b0;

        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, cyc_cnt);
        chk("add_cycles", cyc_cnt, 4);
        chk("add_trace_len", obs_st.size(), 4);
        for (int i = 0; i < 4; i++) chk("add_state_trace", obs_st[i], add_tr[i]);

        run_instr(6'b100011, 6'b000000, 1'b0, 2, 3, cyc_cnt);
        chk("lw_cycles", cyc_cnt, 10);
        chk("lw_ir_pulses", ir_cnt, 1);
        for (int i = 0; i < 10; i++) chk("lw_state_trace", obs_st[i], lw_tr[i]);

        run_instr(6'b101011, 6'b000000, 1'b0, 0, 0, cyc_cnt);
        chk("sw_cycles", cyc_cnt, 4);
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, cyc_cnt);
        chk("beq_cycles", cyc_cnt, 3);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, cyc_cnt);
        run_instr(6'b000101, 6'b000000, 1'b1, 0, 0, cyc_cnt);
        run_instr(6'b000101, 6'b000000, 1'b0, 0, 0, cyc_cnt);
        run_instr(6'b001101, 6'b000000, 1'b0, 0, 0, cyc_cnt);
        run_instr(6'b001111, 6'b000000, 1'b0, 0, 0, cyc_cnt);
        run_instr(6'b001100, 6'b000000, 1'b0, 0, 0, cyc_cnt);
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0, cyc_cnt);
        chk("addi_cycles", cyc_cnt, 4);
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, cyc_cnt);
        run_instr(6'b000011, 6'b000000, 1'b0, 0, 0, cyc_cnt);
        chk("jal_cycles", cyc_cnt, 3);
        run_instr(6'b000000, 6'b001000, 1'b0, 1, 0, cyc_cnt);
        chk("jr_cycles", cyc_cnt, 4);
        run_instr(6'b000000, 6'b100111, 1'b0, 0, 0, cyc_cnt);
        run_instr(6'b000000, 6'b000010, 1'b0, 0, 0, cyc_cnt);
        run_instr(6'b000000, 6'b000001, 1'b0, 0, 0, cyc_cnt);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, cyc_cnt);
        chk("illegal_cycles", cyc_cnt, 3);

        // sw stalled in MEM_WRITE, then asynchronous reset mid-cycle
        opcode_i    = 6'b101011;
        mem_ready_i = 1'b1;
        step(fetch_vec(1'b1));
        mwv = v0(1); mwv.sb = 2'd3; mwv.aop = 3'b100;
        step(mwv);
        mwv = v0(2); mwv.sa = 1'b1; mwv.sb = 2'd2; mwv.aop = 3'b101;
        step(mwv);
        mem_ready_i = 1'b0;
        mwv = v0(5); mwv.mw = 1'b1; mwv.iord = 1'b1;
        step(mwv);
        step(mwv);
        q.push_back(mwv);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_state", int'(state_o), 0);
        chk("rst_async_mem_write", int'(mem_write_o), 0);
        chk("rst_async_mem_read", int'(mem_read_o), 1);
        chk("rst_async_reg_write", int'(reg_write_o), 0);
        chk("rst_async_pc_write", int'(pc_write_o), 0);
        @(posedge clk);
        #1;
        mem_ready_i = 1'b1;
        repeat (2) step(fetch_vec(1'b0));
        reset = 1'b0;
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0, cyc_cnt);
        chk("post_reset_sub_cycles", cyc_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback per instruction.
- Drives datapath muxes, register-file and memory enables, and the 3-bit alu_op code consumed by ALU_Control (producer side of that interface).
- Memory accesses use a ready handshake so variable-latency memory is tolerated.

Parameters:
- OPCODE_W, 6, opcode/funct width.
- STATE_W, 4, state register width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- opcode_i  in  6  IR[31:26], valid from DECODE onward.
- funct_i  in  6  IR[5:0].
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes the current access this cycle.
- pc_write_o  out  1  PC load enable (already conditioned by branch).
- i_or_d_o  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- ir_write_o  out  1  IR load.
- reg_write_o  out  1  register-file write.
- reg_dst_o  out  2  write register: 0=rt, 1=rd, 2=$31.
- mem_to_reg_o  out  2  write data: 0=ALUOut, 1=MDR, 2=PC.
- alu_src_a_o  out  1  0=PC, 1=rs.
- alu_src_b_o  out  2  0=rt, 1=const 4, 2=extended imm, 3=imm<<2.
- alu_op_o  out  3  code to ALU_Control.
- pc_source_o  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=rs.
- state_o  out  4  current state, for debug.
- illegal_o  out  1  one-cycle pulse on an unsupported opcode or funct.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, ALU_WB=7, EXEC_I=8, BRANCH=9, JUMP=10, JR=11, ILLEGAL=12.
- Outputs are Moore-decoded from state plus the latched opcode op_r and latched funct fn_r. Exceptions: pc_write_o and ir_write_o in FETCH, and pc_write_o in BRANCH, also depend on inputs (see below).
- Any output not listed for a state is 0.
- Reset (async): state=FETCH, op_r=0, fn_r=0. During and after reset the FETCH outputs are driven: mem_read_o=1, alu_src_b_o=1, alu_op_o=100; all other outputs 0.
- Reset asserted mid-instruction aborts it in the same cycle, with no further writes.
- FETCH: mem_read_o=1, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=100, pc_source_o=0.
  - Hold in FETCH while mem_ready_i=0.
  - On mem_ready_i=1: ir_write_o=1 and pc_write_o=1 in that same cycle, next=DECODE.
- DECODE: latch op_r<=opcode_i and fn_r<=funct_i. Compute the branch target: alu_src_a_o=0, alu_src_b_o=3, alu_op_o=100. Next state by opcode_i:
  - 000000 with funct 001000 -> JR.
  - 000000 with funct in {100000, 100010, 100100, 100101, 100111, 000000, 000010} -> EXEC_R.
  - 000000 with any other funct -> ILLEGAL.
  - 100011 or 101011 -> MEM_ADDR.
  - 001000, 001111, 001101, 001100 -> EXEC_I.
  - 000100 or 000101 -> BRANCH.
  - 000010 or 000011 -> JUMP.
  - Anything else -> ILLEGAL.
- MEM_ADDR: alu_src_a_o=1, alu_src_b_o=2, alu_op_o=101. Next is MEM_READ if op_r=100011, otherwise MEM_WRITE.
- MEM_READ: mem_read_o=1, i_or_d_o=1. Hold until mem_ready_i, then MEM_WB.
- MEM_WB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1. Next FETCH.
- MEM_WRITE: mem_write_o=1, i_or_d_o=1. Hold until mem_ready_i, then FETCH.
  - mem_write_o stays high for every hold cycle.
- EXEC_R: alu_src_a_o=1, alu_src_b_o=0, alu_op_o=111. Next ALU_WB.
- EXEC_I: alu_src_a_o=1, alu_src_b_o=2. alu_op_o by op_r: addi=100, lui=001, ori=010, andi=011. Next ALU_WB.
- ALU_WB: reg_write_o=1, mem_to_reg_o=0. reg_dst_o=1 if op_r=000000, else 0. Next FETCH.
- BRANCH: alu_src_a_o=1, alu_src_b_o=0, alu_op_o=110, pc_source_o=1. Next FETCH.
  - pc_write_o = (op_r=000100 & zero_i) | (op_r=000101 & ~zero_i).
- JUMP: pc_write_o=1, pc_source_o=2. Next FETCH.
  - For jal (000011) also: reg_write_o=1, reg_dst_o=2, mem_to_reg_o=2. PC already holds PC+4.
- JR: pc_write_o=1, pc_source_o=3, alu_op_o=111. Next FETCH.
- ILLEGAL: illegal_o=1 for exactly one cycle, no writes, next FETCH.
- Cycle counts with zero wait states: R/I ALU=4, lw=5, sw=4, beq/bne=3, j/jal/jr=3. Each wait cycle on mem_ready_i adds 1 cycle.

Test Plan:
- reset held, then released, mem_ready_i=1, opcode 000000 funct 100000 -> state sequence 0,1,6,7,0. alu_op_o=111 in state 6. reg_write_o=1 and reg_dst_o=1 only in state 7.
- lw (100011) with mem_ready_i low 2 cycles in FETCH and 3 cycles in MEM_READ -> 10 cycles total. ir_write_o pulses once. reg_write_o=1 with mem_to_reg_o=1 only in MEM_WB. alu_op_o=101 in MEM_ADDR.
- beq with zero_i=1 -> pc_write_o=1 in BRANCH. beq with zero_i=0 -> 0. bne inverts both cases. alu_op_o=110. Each instruction takes 3 cycles.
- ori (001101), lui (001111), andi (001100), addi (001000) -> alu_op_o in EXEC_I equals 010, 001, 011, 100 respectively. ALU_WB has reg_dst_o=0.
- jal -> JUMP state has pc_write_o=1, pc_source_o=2, reg_write_o=1, reg_dst_o=2, mem_to_reg_o=2. jr -> pc_source_o=3.
- opcode 111111, then separately reset asserted in MEM_WRITE -> first case: illegal_o high one cycle, then FETCH with no writes. Second case: state_o=0 immediately (asynchronous), mem_write_o=0, no writes occur.
